// File: rtl/gb_cpu_fetch_seq.sv
// Game Boy CPU opcode/immediate fetch sequencer.
// Assembles opcode, CB prefix and imm8/imm16 bytes into one instruction.
package gb_cpu_fetch_pkg;
    typedef enum logic [2:0] {
        READ_OPCODE    = 3'd0,
        READ_CB_OPCODE = 3'd1,
        READ_R8        = 3'd2,
        READ_R16_BYTE0 = 3'd3,
        READ_R16_BYTE1 = 3'd4
    } decoder_state_t;
endpackage

module gb_cpu_fetch_seq
    import gb_cpu_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           fetch_en,
    input  logic           pc_load,
    input  logic [15:0]    pc_load_addr,
    output logic           mem_req,
    output logic [15:0]    mem_addr,
    input  logic           mem_ack,
    input  logic [7:0]     mem_rdata,
    output decoder_state_t decoder_state,
    output logic [7:0]     opcode,
    output logic           instr_valid,
    input  logic           instr_ready,
    output logic           instr_cb,
    output logic [15:0]    instr_imm,
    output logic [15:0]    instr_pc,
    output logic           locked
);

    localparam logic [2:0] FETCH_OP       = 3'd0;
    localparam logic [2:0] FETCH_CB       = 3'd1;
    localparam logic [2:0] FETCH_IMM8     = 3'd2;
    localparam logic [2:0] FETCH_IMM16_LO = 3'd3;
    localparam logic [2:0] FETCH_IMM16_HI = 3'd4;
    localparam logic [2:0] ISSUE          = 3'd5;
    localparam logic [2:0] LOCK           = 3'd6;

    logic [2:0]  state;
    logic [2:0]  op_next;
    logic [15:0] pc;
    // Keeps an opcode request alive once raised, even if fetch_en drops.
    logic        op_pend;
    logic        is_lock;
    logic        is_imm8;
    logic        is_imm16;

    always_comb begin
        is_lock = mem_rdata inside {
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD
        };
        is_imm8 = (mem_rdata[2:0] == 3'b110 &&
                   (mem_rdata[7:6] == 2'b00 || mem_rdata[7:6] == 2'b11))
                  || mem_rdata inside {
                      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
                      8'hE0, 8'hE8, 8'hF0, 8'hF8
                  };
        is_imm16 = (mem_rdata[7:6] == 2'b00 && mem_rdata[3:0] == 4'b0001)
                   || mem_rdata inside {
                       8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
                       8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA
                   };
        op_next = ISSUE;
        if (mem_rdata == 8'hCB) begin
            op_next = FETCH_CB;
        end else if (is_lock) begin
            op_next = LOCK;
        end else if (is_imm8) begin
            op_next = FETCH_IMM8;
        end else if (is_imm16) begin
            op_next = FETCH_IMM16_LO;
        end
    end

    always_comb begin
        mem_req = 1'b0;
        if (rst_n) begin
            unique case (state)
                FETCH_OP:       mem_req = fetch_en | op_pend;
                FETCH_CB,
                FETCH_IMM8,
                FETCH_IMM16_LO,
                FETCH_IMM16_HI: mem_req = 1'b1;
                default:        mem_req = 1'b0;
            endcase
        end
    end

    always_comb begin
        decoder_state = READ_OPCODE;
        unique case (state)
            FETCH_CB:       decoder_state = READ_CB_OPCODE;
            FETCH_IMM8:     decoder_state = READ_R8;
            FETCH_IMM16_LO: decoder_state = READ_R16_BYTE0;
            FETCH_IMM16_HI: decoder_state = READ_R16_BYTE1;
            default:        decoder_state = READ_OPCODE;
        endcase
    end

    assign mem_addr    = pc;
    assign instr_valid = (state == ISSUE);
    assign locked      = (state == LOCK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH_OP;
            pc        <= RESET_PC;
            op_pend   <= 1'b0;
            opcode    <= 8'h00;
            instr_cb  <= 1'b0;
            instr_imm <= 16'h0000;
            instr_pc  <= RESET_PC;
        end else if (state != LOCK) begin
            if (pc_load) begin
                pc      <= pc_load_addr;
                state   <= FETCH_OP;
                op_pend <= 1'b0;
            end else begin
                unique case (state)
                    FETCH_OP: begin
                        if (mem_req && mem_ack) begin
                            pc        <= pc + 16'd1;
                            opcode    <= mem_rdata;
                            instr_pc  <= pc;
                            instr_imm <= 16'h0000;
                            instr_cb  <= 1'b0;
                            op_pend   <= 1'b0;
                            state     <= op_next;
                        end else begin
                            op_pend <= mem_req;
                        end
                    end
                    FETCH_CB: begin
                        if (mem_ack) begin
                            pc       <= pc + 16'd1;
                            opcode   <= mem_rdata;
                            instr_cb <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                    FETCH_IMM8: begin
                        if (mem_ack) begin
                            pc             <= pc + 16'd1;
                            instr_imm[7:0] <= mem_rdata;
                            state          <= ISSUE;
                        end
                    end
                    FETCH_IMM16_LO: begin
                        if (mem_ack) begin
                            pc             <= pc + 16'd1;
                            instr_imm[7:0] <= mem_rdata;
                            state          <= FETCH_IMM16_HI;
                        end
                    end
                    FETCH_IMM16_HI: begin
                        if (mem_ack) begin
                            pc              <= pc + 16'd1;
                            instr_imm[15:8] <= mem_rdata;
                            state           <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (instr_ready) begin
                            state <= FETCH_OP;
                        end
                    end
                    default: state <= FETCH_OP;
                endcase
            end
        end
    end

endmodule

// File: doc/gb_cpu_fetch_seq.md
GB_CPU_FETCH_SEQ -- requirements
Module: gb_cpu_fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC loaded on reset.
REQ-002 SHALL have ports, in order:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- fetch_en  in  1  permits starting a new opcode fetch.
- pc_load  in  1  redirect strobe from execute.
- pc_load_addr  in  16  redirect target.
- mem_req  out  1  byte read request.
- mem_addr  out  16  read address.
- mem_ack  in  1  read complete; mem_rdata valid this cycle.
- mem_rdata  in  8  read data.
- decoder_state  out  decoder_state_t  current fetch phase, to decoder.
- opcode  out  8  last opcode byte (CB second byte when prefixed).
- instr_valid  out  1  assembled instruction available.
- instr_ready  in  1  execute accepts instruction.
- instr_cb  out  1  instruction was CB-prefixed.
- instr_imm  out  16  immediate {hi,lo}; imm8 in [7:0], [15:8]=0.
- instr_pc  out  16  address of first instruction byte.
- locked  out  1  hard-lock opcode fetched.

Function
REQ-003 SHALL implement states FETCH_OP, FETCH_CB, FETCH_IMM8, FETCH_IMM16_LO, FETCH_IMM16_HI, ISSUE, LOCK.
REQ-004 decoder_state SHALL be READ_OPCODE in FETCH_OP/ISSUE/LOCK, READ_CB_OPCODE in FETCH_CB, READ_R8 in FETCH_IMM8, READ_R16_BYTE0 in FETCH_IMM16_LO, READ_R16_BYTE1 in FETCH_IMM16_HI.
REQ-005 mem_req SHALL be high in FETCH_CB/IMM8/IMM16_LO/IMM16_HI, and in FETCH_OP only when fetch_en=1; low in ISSUE and LOCK.
REQ-006 mem_addr SHALL equal PC; mem_req and mem_addr SHALL hold stable until the cycle mem_ack=1.
REQ-007 On each acked byte PC SHALL increment by 1, wrapping 16'hFFFF -> 16'h0000.
REQ-008 FETCH_OP ack: latch opcode, instr_pc<=PC, clear instr_imm and instr_cb, then branch on the byte:
- 8'hCB -> FETCH_CB.
- D3,DB,DD,E3,E4,EB,EC,ED,F4,FC,FD -> LOCK.
- imm8 set (00_???110, 10, 18, 20, 28, 30, 38, 11_???110, E0, E8, F0, F8) -> FETCH_IMM8.
- imm16 set (00_??0001, 08, C2, C3, C4, CA, CC, CD, D2, D4, DA, DC, EA, FA) -> FETCH_IMM16_LO.
- otherwise -> ISSUE.
REQ-009 FETCH_CB ack: opcode<=byte, instr_cb<=1, -> ISSUE (CB ops take no immediate).
REQ-010 FETCH_IMM8 ack: instr_imm[7:0]<=byte, -> ISSUE.
REQ-011 FETCH_IMM16_LO ack: instr_imm[7:0]<=byte, -> FETCH_IMM16_HI; HI ack: instr_imm[15:8]<=byte, -> ISSUE.
REQ-012 No ack: SHALL remain in current state; unbounded wait permitted.
REQ-013 instr_valid SHALL be 1 exactly in ISSUE; instr_* outputs SHALL be stable while instr_valid=1.
REQ-014 ISSUE with instr_ready=1: -> FETCH_OP next cycle; opcode fetch may start that cycle (one-bubble issue).
REQ-015 pc_load=1 in any state except LOCK: PC<=pc_load_addr, -> FETCH_OP next cycle, partial instruction discarded, instr_valid low next cycle.
REQ-016 pc_load coincident with mem_ack: redirect wins; byte discarded; PC SHALL NOT also increment.
REQ-017 pc_load coincident with ISSUE handshake: handshake completes, redirect applies.
REQ-018 fetch_en low SHALL only block the start of FETCH_OP; fetches already in CB/immediate states SHALL complete.
REQ-019 LOCK: locked=1, all pc_load/fetch_en/mem_ack ignored until reset.

Reset
REQ-020 rst_n=0 at a clock edge SHALL set: state FETCH_OP, PC=RESET_PC, mem_req=0 during reset, instr_valid=0, locked=0, opcode=8'h00, instr_cb=0, instr_imm=16'h0000, instr_pc=RESET_PC.
REQ-021 Reset mid-fetch or in ISSUE/LOCK SHALL abandon all state; no stale instr_valid after release.

Verification
REQ-022 Bench SHALL cover:
- Memory 0x0000={00}, zero-wait ack, instr_ready=1 -> instr_valid with opcode=00, imm=0000, instr_pc=0000; next fetch addr 0001.
- Bytes {C3,50,01} at 0x0000 -> states READ_OPCODE, READ_R16_BYTE0, READ_R16_BYTE1; ISSUE opcode=C3, imm=0150, PC=0003.
- Bytes {CB,37} with 3-cycle ack latency per byte -> instr_cb=1, opcode=37, imm=0000, mem_addr held during waits.
- Bytes {3E,...}, pc_load=1 addr 0x4000 same cycle as imm8 ack -> no ISSUE, next mem_addr=4000.
- Byte D3 fetched, then pc_load and fetch_en toggled -> locked=1, mem_req=0 until rst_n=0; after reset PC=RESET_PC.
- PC=FFFF, opcode 18 -> imm fetched from 0000, instr_pc=FFFF, PC=0001.
